// File: rtl/clock_gen_pkg.sv
// Shared types and width helpers for the clock_gen divider bank.
// No ports; imported by the interface, the channel and the top.
package clock_gen_pkg;

  typedef enum logic [1:0] {
    ST_ALIGN,
    ST_SETTLE,
    ST_LOCKED
  } state_e;

  // A one-channel bank still needs a 1-bit index port.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter and phase width: one bit wider than H so 2H never overflows.
  function automatic int cnt_w(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/clock_gen_if.sv
// Config bus and clock outputs of clock_gen.
// master: cfg_we/cfg_channel/cfg_half/cfg_phase/cfg_commit out; clocks, locked, cfg_error in.
interface clock_gen_if
  import clock_gen_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int DIV_WIDTH    = 8
);

  localparam int CHW = chan_w(NUM_CHANNELS);
  localparam int CW  = cnt_w(DIV_WIDTH);

  logic                    cfg_we;
  logic [CHW-1:0]          cfg_channel;
  logic [DIV_WIDTH-1:0]    cfg_half;
  logic [CW-1:0]           cfg_phase;
  logic                    cfg_commit;
  logic [NUM_CHANNELS-1:0] clk_out;
  logic [NUM_CHANNELS-1:0] clk_strobe;
  logic                    locked;
  logic                    cfg_error;

  modport master (
    output cfg_we,
    output cfg_channel,
    output cfg_half,
    output cfg_phase,
    output cfg_commit,
    input  clk_out,
    input  clk_strobe,
    input  locked,
    input  cfg_error
  );

  modport slave (
    input  cfg_we,
    input  cfg_channel,
    input  cfg_half,
    input  cfg_phase,
    input  cfg_commit,
    output clk_out,
    output clk_strobe,
    output locked,
    output cfg_error
  );

endinterface

// File: rtl/clock_gen_channel.sv
// One divider channel: active H/P, phase counter, clamp detect, registered outputs.
// Ports: clk, reset, align (load pulse), commit, sh_half/sh_phase in; clk_out, clk_strobe, clamp out.
module clock_gen_channel
  import clock_gen_pkg::*;
#(
  parameter int DIV_WIDTH    = 8,
  parameter int DEFAULT_HALF = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         align,
  input  logic                         commit,
  input  logic [DIV_WIDTH-1:0]         sh_half,
  input  logic [cnt_w(DIV_WIDTH)-1:0]  sh_phase,
  output logic                         clk_out,
  output logic                         clk_strobe,
  output logic                         clamp
);

  localparam int CW = cnt_w(DIV_WIDTH);

  logic [DIV_WIDTH-1:0] half;
  logic [CW-1:0]        phase;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        two_h;
  logic                 en;

  assign two_h = {half, 1'b0};
  assign en    = (half != '0);

  // A disabled channel has no period, so its phase is never clamped.
  assign clamp = align && en && (phase >= two_h);

  always_ff @(posedge clk) begin
    if (reset) begin
      half       <= DIV_WIDTH'(DEFAULT_HALF);
      phase      <= '0;
      cnt        <= '0;
      clk_out    <= 1'b0;
      clk_strobe <= 1'b0;
    end else begin
      if (commit) begin
        half  <= sh_half;
        phase <= sh_phase;
      end
      if (align) begin
        // Counter is stale during the load cycle; hold outputs low
        // so every channel starts cleanly from the shared edge.
        cnt        <= (clamp || !en) ? '0 : phase;
        clk_out    <= 1'b0;
        clk_strobe <= 1'b0;
      end else if (en) begin
        cnt        <= (cnt == two_h - 1'b1) ? '0 : cnt + 1'b1;
        clk_out    <= (cnt < {1'b0, half});
        clk_strobe <= (cnt == '0);
      end else begin
        clk_out    <= 1'b0;
        clk_strobe <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_gen.sv
// Reprogrammable clock-divider bank with shared alignment and emulated PLL lock.
// Ports: clk, reset (sync, active high), bus (slave: config in, clocks/locked/cfg_error out).
module clock_gen
  import clock_gen_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int DIV_WIDTH    = 8,
  parameter int LOCK_CYCLES  = 16,
  parameter int DEFAULT_HALF = 1
) (
  input  logic       clk,
  input  logic       reset,
  clock_gen_if.slave bus
);

  localparam int CHW = chan_w(NUM_CHANNELS);
  localparam int CW  = cnt_w(DIV_WIDTH);
  localparam int LW  = $clog2(LOCK_CYCLES) + 1;

  state_e                  state;
  state_e                  state_nxt;
  logic [LW-1:0]           lock_cnt;
  logic [LW-1:0]           lock_nxt;
  logic                    locked_q;
  logic                    locked_nxt;
  logic                    err_q;
  logic                    err_nxt;
  logic                    align;
  logic                    bad_ch;
  logic [NUM_CHANNELS-1:0] clamp;
  logic [NUM_CHANNELS-1:0] ch_out;
  logic [NUM_CHANNELS-1:0] ch_stb;

  assign align  = (state == ST_ALIGN);
  assign bad_ch = bus.cfg_we &&
    ({1'b0, bus.cfg_channel} >= (CHW+1)'(NUM_CHANNELS));

  always_comb begin
    state_nxt  = state;
    lock_nxt   = lock_cnt;
    locked_nxt = 1'b0;
    unique case (state)
      ST_ALIGN: begin
        state_nxt = ST_SETTLE;
        lock_nxt  = '0;
      end
      ST_SETTLE: begin
        if (lock_cnt == LW'(LOCK_CYCLES - 1))
          state_nxt = ST_LOCKED;
        else
          lock_nxt = lock_cnt + 1'b1;
      end
      ST_LOCKED: locked_nxt = 1'b1;
      default:   state_nxt  = ST_ALIGN;
    endcase
    // Commit wins from any state and drops lock immediately.
    if (bus.cfg_commit) begin
      state_nxt  = ST_ALIGN;
      locked_nxt = 1'b0;
    end
  end

  assign err_nxt = err_q | bad_ch | (|clamp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_ALIGN;
      lock_cnt <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_nxt;
      locked_q <= locked_nxt;
      err_q    <= err_nxt;
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic                 hit;
    logic [DIV_WIDTH-1:0] half_q;
    logic [DIV_WIDTH-1:0] half_n;
    logic [CW-1:0]        phase_q;
    logic [CW-1:0]        phase_n;

    assign hit = bus.cfg_we && (bus.cfg_channel == CHW'(i));

    // Same-cycle write and commit: the commit sees the written value.
    assign half_n  = hit ? bus.cfg_half  : half_q;
    assign phase_n = hit ? bus.cfg_phase : phase_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        half_q  <= DIV_WIDTH'(DEFAULT_HALF);
        phase_q <= '0;
      end else begin
        half_q  <= half_n;
        phase_q <= phase_n;
      end
    end

    clock_gen_channel #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_HALF(DEFAULT_HALF)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .align     (align),
      .commit    (bus.cfg_commit),
      .sh_half   (half_n),
      .sh_phase  (phase_n),
      .clk_out   (ch_out[i]),
      .clk_strobe(ch_stb[i]),
      .clamp     (clamp[i])
    );
  end

  assign bus.clk_out    = ch_out;
  assign bus.clk_strobe = ch_stb;
  assign bus.locked     = locked_q;
  assign bus.cfg_error  = err_q;

endmodule

// File: tb/tb_clock_gen.sv
// Scoreboard bench for clock_gen: directed scenarios then random config traffic.
// Expected values come from an arithmetic model of channel phase since alignment.
module tb_clock_gen;
  import clock_gen_pkg::*;

  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int LC  = 16;
  localparam int DH  = 1;
  localparam int CHW = chan_w(N);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  clock_gen_if #(.NUM_CHANNELS(N), .DIV_WIDTH(DW)) bus ();

  clock_gen #(
    .NUM_CHANNELS(N),
    .DIV_WIDTH   (DW),
    .LOCK_CYCLES (LC),
    .DEFAULT_HALF(DH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [N-1:0] out;
    logic [N-1:0] stb;
    logic         lk;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  int sh_h[N], sh_p[N], act_h[N], act_p[N], pc[N];
  int a_edge = 0;
  int cyc = 0;
  bit align_nxt = 1'b1;
  bit m_err = 1'b0;

  task automatic step(input bit rst, input bit we, input int ch,
                      input int h, input int p, input bit cm);
    exp_t e;
    @(negedge clk);
    reset = rst;
    bus.cfg_we = we;
    bus.cfg_channel = CHW'(ch);
    bus.cfg_half = DW'(h);
    bus.cfg_phase = (DW+1)'(p);
    bus.cfg_commit = cm;
    e.out = '0;
    e.stb = '0;
    e.lk = 1'b0;
    e.cyc = cyc;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        sh_h[i] = DH; sh_p[i] = 0;
        act_h[i] = DH; act_p[i] = 0;
      end
      align_nxt = 1'b1;
      m_err = 1'b0;
    end else begin
      if (align_nxt) begin
        a_edge = cyc;
        for (int i = 0; i < N; i++) begin
          bit cl;
          cl = (act_h[i] != 0) && (act_p[i] >= 2 * act_h[i]);
          pc[i] = cl ? 0 : act_p[i];
          if (cl) m_err = 1'b1;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (act_h[i] != 0) begin
            int ph;
            ph = (pc[i] + cyc - 1 - a_edge) % (2 * act_h[i]);
            e.out[i] = (ph < act_h[i]);
            e.stb[i] = (ph == 0);
          end
        end
      end
      e.lk = !align_nxt && !cm && (cyc >= a_edge + LC + 1);
      if (we) begin
        if (ch < N) begin
          sh_h[ch] = h;
          sh_p[ch] = p;
        end else begin
          m_err = 1'b1;
        end
      end
      if (cm)
        for (int i = 0; i < N; i++) begin
          act_h[i] = sh_h[i];
          act_p[i] = sh_p[i];
        end
      align_nxt = cm;
    end
    e.err = m_err;
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int ch, input int h, input int p);
    step(1'b0, 1'b1, ch, h, p, 1'b0);
  endtask

  task automatic commit();
    step(1'b0, 1'b0, 0, 0, 0, 1'b1);
  endtask

  task automatic chk(input string nm, input int c,
                     input logic [N-1:0] act, input logic [N-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, c, act, req);
    end
  endtask

  exp_t me;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("clk_out", me.cyc, bus.clk_out, me.out);
        chk("clk_strobe", me.cyc, bus.clk_strobe, me.stb);
        chk("locked", me.cyc, N'(bus.locked), N'(me.lk));
        chk("cfg_error", me.cyc, N'(bus.cfg_error), N'(me.err));
      end
    end
  end

  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_channel = '0;
    bus.cfg_half = '0;
    bus.cfg_phase = '0;
    bus.cfg_commit = 1'b0;

    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    idle(30);

    wr(0, 4, 0); wr(1, 5, 0); wr(2, 10, 0);
    idle(3);
    commit();
    idle(50);

    wr(1, 4, 3);
    commit();
    idle(40);

    wr(2, 3, 6);
    commit();
    idle(30);
    wr(3, 7, 1);
    idle(10);

    step(1'b0, 1'b1, 0, 2, 0, 1'b1);
    idle(5);
    commit();
    idle(30);

    wr(0, 0, 0);
    commit();
    idle(30);
    step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    idle(25);

    for (int k = 0; k < 3000; k++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 2)
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
      else if (r < 80)
        step(1'b0, 1'b1, $urandom_range(0, 3), $urandom_range(0, 6),
             $urandom_range(0, 14), $urandom_range(0, 19) == 0);
      else if (r < 100)
        commit();
      else
        idle(1);
    end

    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
